// File: rtl/sdram_responder_if.sv
// Command/data bus between the REU RAM controller and the SDRAM device.
interface sdram_responder_if;
   logic        CKE;
   logic        nCS;
   logic        nRAS;
   logic        nCAS;
   logic        nRWE;
   logic [1:0]  RBA;
   logic [12:0] RA;
   logic        DQMH;
   logic        DQML;
   logic [7:0]  RD_I;
   logic [7:0]  RD_O;
   logic        RD_OE;
   logic        MODE_OK;
   logic        ERR;
   logic [2:0]  ERR_CODE;

   // Controller side
   modport master (
      output CKE, nCS, nRAS, nCAS, nRWE, RBA, RA, DQMH, DQML, RD_I,
      input  RD_O, RD_OE, MODE_OK, ERR, ERR_CODE
   );

   // Device side
   modport slave (
      input  CKE, nCS, nRAS, nCAS, nRWE, RBA, RA, DQMH, DQML, RD_I,
      output RD_O, RD_OE, MODE_OK, ERR, ERR_CODE
   );
endinterface

// File: rtl/sdram_responder.sv
// Single-device 8-bit SDR SDRAM model: command decode, per-bank open-row
// tracking, on-chip byte storage, CAS-latency read pipeline, violation flags.
module sdram_responder #(
   parameter int unsigned MEM_AW   = 12,
   parameter int unsigned COL_BITS = 9
) (
   input  logic               RCLK,
   input  logic               RESET,
   sdram_responder_if.slave   bus
);
   localparam logic [3:0] CMD_LOAD  = 4'b0000;
   localparam logic [3:0] CMD_REF   = 4'b0001;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_BST   = 4'b0110;

   logic [7:0]              r_mem [2**MEM_AW];
   logic [3:0]              r_open;
   logic [3:0][12:0]        r_row;
   logic                    r_cl3;
   logic                    r_mode_ok;
   logic                    r_err;
   logic [2:0]              r_err_code;
   logic [2:0]              r_pv;
   logic [2:0]              r_poe;
   logic [2:0][7:0]         r_pd;
   logic [7:0]              r_rd_o;
   logic                    r_rd_oe;

   logic [3:0]              w_cmd;
   logic [14+COL_BITS:0]    w_full_addr;
   logic [MEM_AW-1:0]       w_idx;
   logic [7:0]              w_rd_data;
   logic                    w_tap_v, w_tap_oe, w_pre_v, w_pre_oe;
   logic [7:0]              w_tap_d;
   logic                    w_contend;
   logic [3:0]              w_open_d;
   logic [3:0][12:0]        w_row_d;
   logic                    w_cl3_d;
   logic                    w_mode_ok_d;
   logic                    w_err_d;
   logic [2:0]              w_code_d;
   logic                    w_issue, w_issue_oe, w_we;
   logic                    w_unused;

   assign w_cmd       = {bus.nCS, bus.nRAS, bus.nCAS, bus.nRWE};
   assign w_full_addr = {bus.RBA, r_row[bus.RBA], bus.RA[COL_BITS-1:0]};
   assign w_idx       = w_full_addr[MEM_AW-1:0];
   assign w_rd_data   = r_mem[w_idx];
   // Upper lane mask is meaningless on a byte-wide part; high address bits fall off the store
   assign w_unused    = ^{bus.DQMH, w_full_addr};

   // Pipeline tap that feeds RD_OE at this edge, and the stage that feeds it one edge later
   assign w_tap_v   = r_cl3 ? r_pv[2]  : r_pv[1];
   assign w_tap_oe  = r_cl3 ? r_poe[2] : r_poe[1];
   assign w_tap_d   = r_cl3 ? r_pd[2]  : r_pd[1];
   assign w_pre_v   = r_cl3 ? r_pv[1]  : r_pv[0];
   assign w_pre_oe  = r_cl3 ? r_poe[1] : r_poe[0];
   assign w_contend = (w_tap_v & w_tap_oe) | (w_pre_v & w_pre_oe);

   // Decode the command sampled at this edge into next bank/mode/error state
   always_comb begin
      w_open_d    = r_open;
      w_row_d     = r_row;
      w_cl3_d     = r_cl3;
      w_mode_ok_d = r_mode_ok;
      w_err_d     = 1'b0;
      w_code_d    = r_err_code;
      w_issue     = 1'b0;
      w_issue_oe  = 1'b0;
      w_we        = 1'b0;
      if (bus.CKE && !bus.nCS) begin
         case (w_cmd)
            CMD_ACT: begin
               if (r_open[bus.RBA]) begin
                  w_err_d  = 1'b1;
                  w_code_d = 3'd1;
               end
               w_open_d[bus.RBA] = 1'b1;
               w_row_d[bus.RBA]  = bus.RA;
            end
            CMD_READ: begin
               if (!r_open[bus.RBA] || !r_mode_ok) begin
                  w_err_d  = 1'b1;
                  w_code_d = 3'd2;
               end else begin
                  w_issue    = 1'b1;
                  w_issue_oe = !bus.DQML;
                  if (bus.RA[10]) w_open_d[bus.RBA] = 1'b0;
               end
            end
            CMD_WRITE: begin
               if (!r_open[bus.RBA] || !r_mode_ok) begin
                  w_err_d  = 1'b1;
                  w_code_d = 3'd2;
               end else begin
                  w_we = !bus.DQML;
                  if (bus.RA[10]) w_open_d[bus.RBA] = 1'b0;
                  if (w_contend) begin
                     w_err_d  = 1'b1;
                     w_code_d = 3'd6;
                  end
               end
            end
            CMD_PRE: begin
               if (bus.RA[10]) w_open_d = '0;
               else            w_open_d[bus.RBA] = 1'b0;
            end
            CMD_REF: begin
               if (|r_open) begin
                  w_err_d  = 1'b1;
                  w_code_d = 3'd3;
               end
            end
            CMD_LOAD: begin
               if (|r_open) begin
                  w_err_d  = 1'b1;
                  w_code_d = 3'd3;
               end else if ((bus.RA[6:4] == 3'd2 || bus.RA[6:4] == 3'd3) &&
                            bus.RA[2:0] == 3'd0) begin
                  w_cl3_d     = bus.RA[4];
                  w_mode_ok_d = 1'b1;
               end else begin
                  w_err_d     = 1'b1;
                  w_code_d    = 3'd4;
                  w_mode_ok_d = 1'b0;
               end
            end
            CMD_BST: begin
               w_err_d  = 1'b1;
               w_code_d = 3'd5;
            end
            default: ;
         endcase
      end
   end

   // Byte storage; deliberately not reset
   always_ff @(posedge RCLK) begin
      if (w_we) r_mem[w_idx] <= bus.RD_I;
   end

   // Control state and read pipeline; pipeline freezes while CKE is low
   always_ff @(posedge RCLK or posedge RESET) begin
      if (RESET) begin
         r_open     <= '0;
         r_row      <= '0;
         r_cl3      <= 1'b1;
         r_mode_ok  <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 3'd0;
         r_pv       <= '0;
         r_poe      <= '0;
         r_pd       <= '0;
         r_rd_o     <= 8'd0;
         r_rd_oe    <= 1'b0;
      end else begin
         r_open     <= w_open_d;
         r_row      <= w_row_d;
         r_cl3      <= w_cl3_d;
         r_mode_ok  <= w_mode_ok_d;
         r_err      <= w_err_d;
         r_err_code <= w_code_d;
         if (bus.CKE) begin
            r_pv    <= {r_pv[1:0], w_issue};
            r_poe   <= {r_poe[1:0], w_issue_oe};
            r_pd    <= {r_pd[1:0], w_rd_data};
            r_rd_oe <= w_tap_v & w_tap_oe;
            if (w_tap_v) r_rd_o <= w_tap_d;
         end
      end
   end

   assign bus.RD_O     = r_rd_o;
   assign bus.RD_OE    = r_rd_oe;
   assign bus.MODE_OK  = r_mode_ok;
   assign bus.ERR      = r_err;
   assign bus.ERR_CODE = r_err_code;
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: mode load, CL2/CL3 reads, masks,
// CKE stall, protocol violations and asynchronous reset mid-read.
module tb_sdram_responder;
   localparam logic [3:0] C_LOAD  = 4'b0000;
   localparam logic [3:0] C_REF   = 4'b0001;
   localparam logic [3:0] C_PRE   = 4'b0010;
   localparam logic [3:0] C_ACT   = 4'b0011;
   localparam logic [3:0] C_WRITE = 4'b0100;
   localparam logic [3:0] C_READ  = 4'b0101;
   localparam logic [3:0] C_BST   = 4'b0110;
   localparam logic [3:0] C_NOP   = 4'b0111;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic err_seen;
   logic oe_seen;

   sdram_responder_if u_bus ();

   sdram_responder u_dut (
      .RCLK  (clk),
      .RESET (rst),
      .bus   (u_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Drive one command across a rising edge, then sample 1ns after it
   task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] ra,
                      input logic [7:0] d, input logic dqml);
      {u_bus.nCS, u_bus.nRAS, u_bus.nCAS, u_bus.nRWE} = c;
      u_bus.RBA  = ba;
      u_bus.RA   = ra;
      u_bus.RD_I = d;
      u_bus.DQML = dqml;
      @(posedge clk);
      #1;
      err_seen = err_seen | u_bus.ERR;
      oe_seen  = oe_seen | u_bus.RD_OE;
   endtask

   task automatic nop();
      cmd(C_NOP, 2'd0, 13'd0, 8'd0, 1'b0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      err_seen = 1'b0;
      oe_seen  = 1'b0;
      rst = 1'b1;
      u_bus.CKE = 1'b1;
      u_bus.DQMH = 1'b0;
      {u_bus.nCS, u_bus.nRAS, u_bus.nCAS, u_bus.nRWE} = C_NOP;
      u_bus.RBA = '0; u_bus.RA = '0; u_bus.RD_I = '0; u_bus.DQML = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_rd_o", 16'(u_bus.RD_O), 16'h00);
      check_eq("rst_rd_oe", 16'(u_bus.RD_OE), 16'h0);
      check_eq("rst_mode_ok", 16'(u_bus.MODE_OK), 16'h0);
      check_eq("rst_err", 16'(u_bus.ERR), 16'h0);
      check_eq("rst_err_code", 16'(u_bus.ERR_CODE), 16'h0);
      @(negedge clk);
      rst = 1'b0;

      // CL2 write then read
      cmd(C_LOAD, 2'd0, 13'h020, 8'h00, 1'b0);
      check_eq("cl2_mode_ok", 16'(u_bus.MODE_OK), 16'h1);
      cmd(C_ACT, 2'd1, 13'h005, 8'h00, 1'b0);
      cmd(C_WRITE, 2'd1, 13'h003, 8'hA5, 1'b0);
      cmd(C_READ, 2'd1, 13'h003, 8'h00, 1'b0);
      nop();
      check_eq("cl2_oe_e1", 16'(u_bus.RD_OE), 16'h0);
      nop();
      check_eq("cl2_oe_e2", 16'(u_bus.RD_OE), 16'h1);
      check_eq("cl2_data", 16'(u_bus.RD_O), 16'hA5);
      nop();
      check_eq("cl2_oe_e3", 16'(u_bus.RD_OE), 16'h0);
      check_eq("cl2_no_err", 16'(err_seen), 16'h0);

      // CL3 back-to-back reads
      err_seen = 1'b0;
      cmd(C_PRE, 2'd0, 13'h400, 8'h00, 1'b0);
      cmd(C_LOAD, 2'd0, 13'h030, 8'h00, 1'b0);
      cmd(C_ACT, 2'd1, 13'h005, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) cmd(C_WRITE, 2'd1, 13'(i), 8'(8'h10 + i), 1'b0);
      cmd(C_READ, 2'd1, 13'd0, 8'h00, 1'b0);
      cmd(C_READ, 2'd1, 13'd1, 8'h00, 1'b0);
      check_eq("cl3_oe_e1", 16'(u_bus.RD_OE), 16'h0);
      cmd(C_READ, 2'd1, 13'd2, 8'h00, 1'b0);
      check_eq("cl3_oe_e2", 16'(u_bus.RD_OE), 16'h0);
      cmd(C_READ, 2'd1, 13'd3, 8'h00, 1'b0);
      check_eq("cl3_oe_b0", 16'(u_bus.RD_OE), 16'h1);
      check_eq("cl3_d_b0", 16'(u_bus.RD_O), 16'h10);
      for (int i = 1; i < 4; i++) begin
         nop();
         check_eq("cl3_oe_bn", 16'(u_bus.RD_OE), 16'h1);
         check_eq("cl3_d_bn", 16'(u_bus.RD_O), 16'(8'h10 + i));
      end
      nop();
      check_eq("cl3_oe_end", 16'(u_bus.RD_OE), 16'h0);
      check_eq("cl3_no_err", 16'(err_seen), 16'h0);

      // Read to closed bank, double activate
      oe_seen = 1'b0;
      cmd(C_READ, 2'd2, 13'd0, 8'h00, 1'b0);
      check_eq("closed_err", 16'(u_bus.ERR), 16'h1);
      check_eq("closed_code", 16'(u_bus.ERR_CODE), 16'h2);
      nop();
      check_eq("err_one_cycle", 16'(u_bus.ERR), 16'h0);
      repeat (3) nop();
      check_eq("closed_no_oe", 16'(oe_seen), 16'h0);
      cmd(C_ACT, 2'd0, 13'h001, 8'h00, 1'b0);
      cmd(C_ACT, 2'd0, 13'h002, 8'h00, 1'b0);
      check_eq("dbl_act_code", 16'(u_bus.ERR_CODE), 16'h1);

      // Illegal mode, then read with MODE_OK low
      cmd(C_PRE, 2'd0, 13'h400, 8'h00, 1'b0);
      cmd(C_LOAD, 2'd0, 13'h011, 8'h00, 1'b0);
      check_eq("bad_mode_code", 16'(u_bus.ERR_CODE), 16'h4);
      check_eq("bad_mode_ok", 16'(u_bus.MODE_OK), 16'h0);
      cmd(C_ACT, 2'd1, 13'h005, 8'h00, 1'b0);
      cmd(C_READ, 2'd1, 13'd0, 8'h00, 1'b0);
      check_eq("nomode_rd_code", 16'(u_bus.ERR_CODE), 16'h2);

      // Masks, CKE stall, contention
      cmd(C_PRE, 2'd0, 13'h400, 8'h00, 1'b0);
      cmd(C_LOAD, 2'd0, 13'h020, 8'h00, 1'b0);
      cmd(C_ACT, 2'd1, 13'h005, 8'h00, 1'b0);
      cmd(C_WRITE, 2'd1, 13'd4, 8'h33, 1'b0);
      cmd(C_WRITE, 2'd1, 13'd4, 8'h5A, 1'b1);
      cmd(C_READ, 2'd1, 13'd4, 8'h00, 1'b0);
      nop(); nop();
      check_eq("dqm_wr_oe", 16'(u_bus.RD_OE), 16'h1);
      check_eq("dqm_wr_data", 16'(u_bus.RD_O), 16'h33);
      oe_seen = 1'b0;
      cmd(C_READ, 2'd1, 13'd0, 8'h00, 1'b1);
      nop(); nop(); nop();
      check_eq("dqm_rd_no_oe", 16'(oe_seen), 16'h0);
      check_eq("dqm_rd_data", 16'(u_bus.RD_O), 16'h10);
      u_bus.CKE = 1'b0;
      cmd(C_READ, 2'd1, 13'd4, 8'h00, 1'b0);
      u_bus.CKE = 1'b1;
      repeat (4) nop();
      check_eq("cke_no_read", 16'(oe_seen), 16'h0);
      cmd(C_READ, 2'd1, 13'd4, 8'h00, 1'b0);
      cmd(C_WRITE, 2'd1, 13'd5, 8'h77, 1'b0);
      check_eq("contend_err", 16'(u_bus.ERR), 16'h1);
      check_eq("contend_code", 16'(u_bus.ERR_CODE), 16'h6);
      nop();
      check_eq("contend_rd_oe", 16'(u_bus.RD_OE), 16'h1);
      check_eq("contend_rd_d", 16'(u_bus.RD_O), 16'h33);
      cmd(C_READ, 2'd1, 13'd5, 8'h00, 1'b0);
      nop(); nop();
      check_eq("contend_wr_done", 16'(u_bus.RD_O), 16'h77);
      cmd(C_REF, 2'd0, 13'd0, 8'h00, 1'b0);
      check_eq("ref_open_code", 16'(u_bus.ERR_CODE), 16'h3);
      cmd(C_BST, 2'd0, 13'd0, 8'h00, 1'b0);
      check_eq("bst_code", 16'(u_bus.ERR_CODE), 16'h5);

      // Reset one cycle before a pending RD_OE
      cmd(C_READ, 2'd1, 13'd4, 8'h00, 1'b0);
      nop();
      rst = 1'b1;
      #1;
      check_eq("mid_rst_oe", 16'(u_bus.RD_OE), 16'h0);
      check_eq("mid_rst_mode", 16'(u_bus.MODE_OK), 16'h0);
      check_eq("mid_rst_code", 16'(u_bus.ERR_CODE), 16'h0);
      @(posedge clk);
      #1;
      check_eq("mid_rst_oe_due", 16'(u_bus.RD_OE), 16'h0);
      @(negedge clk);
      rst = 1'b0;
      cmd(C_LOAD, 2'd0, 13'h020, 8'h00, 1'b0);
      check_eq("post_rst_load_err", 16'(u_bus.ERR), 16'h0);
      check_eq("post_rst_load_ok", 16'(u_bus.MODE_OK), 16'h1);
      cmd(C_READ, 2'd1, 13'd4, 8'h00, 1'b0);
      check_eq("post_rst_closed", 16'(u_bus.ERR_CODE), 16'h2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable single-device SDR SDRAM responder for the REU SDRAM bus. It is the far end of the REU RAM controller's command interface.
- Decodes CS/RAS/CAS/WE commands, tracks open rows per bank, and stores bytes in on-chip RAM. Returns read data after the programmed CAS latency and flags protocol violations.
- Used in place of the external SDRAM for CPLD-less bring-up and in system benches.

Parameters:
- MEM_AW, 12, storage address width; words stored = 2^MEM_AW bytes; index = {bank,row,col} truncated to the low MEM_AW bits.
- COL_BITS, 9, column bits taken from RA[COL_BITS-1:0] on READ/WRITE.

Ports:
- RCLK  in  1  SDRAM clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CKE  in  1  clock enable.
- nCS  in  1  chip select, active low.
- nRAS  in  1  row strobe, active low.
- nCAS  in  1  column strobe, active low.
- nRWE  in  1  write enable, active low.
- RBA  in  2  bank address.
- RA  in  13  row/column/mode address.
- DQMH  in  1  upper-lane mask; ignored (8-bit device).
- DQML  in  1  lower-lane mask.
- RD_I  in  8  write data from controller.
- RD_O  out  8  read data.
- RD_OE  out  1  read data drive enable.
- MODE_OK  out  1  mode register has been loaded with a legal value.
- ERR  out  1  one-cycle pulse on a protocol violation.
- ERR_CODE  out  3  code of the most recent violation; sticky until RESET.

Behaviour:
- Reset values: RD_O=0, RD_OE=0, MODE_OK=0, ERR=0, ERR_CODE=0.
  - All banks are closed. The read pipeline is empty. CL is 3.
  - Storage contents are not reset.
- Command decode uses {nCS,nRAS,nCAS,nRWE} at a rising edge where CKE=1:
  - 1xxx = deselect
  - 0111 = NOP
  - 0011 = ACTIVE
  - 0101 = READ
  - 0100 = WRITE
  - 0010 = PRECHARGE
  - 0001 = REFRESH
  - 0000 = LOAD MODE
  - 0110 = BURST TERMINATE
- CKE=0: the command is ignored and the read pipeline holds (RD_O/RD_OE frozen).
- ACTIVE: latch RA as the open row of bank RBA and mark the bank open. If the bank is already open: ERR code 1, row is replaced.
- READ: if bank RBA is closed, or MODE_OK=0: ERR code 2, no data returned.
  - Otherwise fetch byte at {RBA, open row, RA[COL_BITS-1:0]}.
  - RD_OE rises CL edges after the READ edge and stays high exactly one cycle (burst length 1), with RD_O = that byte.
  - DQML=1 sampled with READ suppresses RD_OE for that read; RD_O is still updated.
  - RA[10] (auto-precharge) closes the bank after the fetch.
- WRITE: bank closed or MODE_OK=0 gives ERR code 2, no write.
  - Otherwise, if DQML=0, store RD_I at the same address in that cycle. DQML=1 skips the store.
  - RA[10] auto-precharges.
- Write data is visible to a READ issued on the next edge (same-row read-after-write returns the new byte).
- PRECHARGE: RA[10]=1 closes all banks, else closes bank RBA. Precharging a closed bank is legal and silent.
- REFRESH: legal only with all banks closed. Otherwise ERR code 3 and the banks stay open.
- LOAD MODE: legal only with all banks closed, else ERR code 3 and ignored.
  - RA[6:4] gives CL; allowed values are 2 and 3.
  - RA[2:0] must be 000 (BL1). RA[3] is don't-care.
  - Legal value: set CL and MODE_OK=1.
  - Illegal value: ERR code 4, MODE_OK=0, CL unchanged.
- BURST TERMINATE: unsupported, ERR code 5, otherwise NOP.
- Read pipeline is a CL-deep shift; back-to-back READs each edge produce back-to-back RD_OE cycles.
- A WRITE issued while a read is in flight (RD_OE due within 1 cycle of the WRITE): ERR code 6 (bus contention). The write still executes and the read still returns.
- Simultaneous violations in one cycle cannot occur (one command per edge).
- ERR is registered: it pulses the cycle after the offending edge.
- RESET asserted mid-read flushes the pipeline, so RD_OE drops immediately.

Test Plan:
- LOAD MODE RA=0x020 (CL2), ACTIVE bank1 row 0x005, WRITE col 0x03 data 0xA5, READ col 0x03 -> RD_OE high exactly 2 edges after READ with RD_O=0xA5; MODE_OK=1, ERR never pulses.
- Same sequence with RA=0x030 (CL3) and 4 back-to-back READs cols 0..3 preloaded 0x10..0x13 -> RD_OE high 4 consecutive cycles starting 3 edges after first READ, data 0x10,0x11,0x12,0x13.
- READ to a closed bank 2 -> ERR pulse, ERR_CODE=2, no RD_OE. Then ACTIVE bank0 twice -> ERR_CODE=1.
- LOAD MODE RA=0x011 (CL1, BL2) -> ERR_CODE=4, MODE_OK=0. A following READ -> ERR_CODE=2.
- WRITE 0x5A with DQML=1 over an existing 0x33 -> read back 0x33. READ with DQML=1 -> RD_OE stays 0. CKE=0 during a READ edge -> no read issued.
- Assert RESET one cycle before a pending RD_OE -> RD_OE=0 immediately, all banks closed, MODE_OK=0, ERR_CODE=0.
